// File: rtl/day_7_row_parser_pkg.sv
// day_7_pkg: grid size defaults, ASCII constants and parser states shared with the path-counting stage
package day_7_pkg;
  localparam int DEF_WIDTH  = 141;
  localparam int DEF_HEIGHT = 141;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_HAT = 8'h5E;
  localparam logic [7:0] CH_S   = 8'h53;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  typedef enum logic [2:0] {IDLE, SCAN, EMIT, DONE, ERR} state_t;
endpackage

// File: rtl/day_7_row_parser_if.sv
// day_7_row_parser_if: byte-in / row-out handshake bundle
// Ports: in_valid/in_ready/in_data carry the ASCII stream, row_valid/row_ready/row_data/row_index carry
// one splitter bitmap per grid row. slave = parser side, master = producer/consumer side.
interface day_7_row_parser_if #(parameter int WIDTH = 141);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             row_valid;
  logic             row_ready;
  logic [WIDTH-1:0] row_data;
  logic [7:0]       row_index;
  modport slave (input in_valid, in_data, row_ready, output in_ready, row_valid, row_data, row_index);
  modport master (output in_valid, in_data, row_ready, input in_ready, row_valid, row_data, row_index);
endinterface

// File: rtl/day_7_row_parser.sv
// day_7_row_parser: turns the day-7 ASCII grid into one splitter bitmap per row and locates 'S'
// Ports: clk, rst (sync, active-low), start (begins a parse from IDLE), bus (day_7_row_parser_if.slave),
// start_col/start_found ('S' column in row 0), finished (all rows emitted), error (sticky fault).
// Optional: define DAY7_ROW_CHECK_EN to trap malformed input in ERR; otherwise faults are tolerated.
module day_7_row_parser
  import day_7_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  day_7_row_parser_if.slave   bus,
  output logic [7:0]          start_col,
  output logic                start_found,
  output logic                finished,
  output logic                error
);
  localparam int CW = $clog2(WIDTH + 2);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_col;
  logic [WIDTH-1:0] r_buf, w_mask;
  logic [7:0]       r_row_index, r_start_col;
  logic             r_start_found;
  logic             w_acc, w_lf, w_cr, w_hat, w_s, w_in_row, w_row_hs, w_fault;
  assign w_acc    = bus.in_valid && r_state == SCAN;
  assign w_lf     = bus.in_data == CH_LF;
  assign w_cr     = bus.in_data == CH_CR;
  assign w_hat    = bus.in_data == CH_HAT;
  assign w_s      = bus.in_data == CH_S;
  assign w_in_row = r_col < CW'(WIDTH);
  // column c maps to bit WIDTH-1-c; columns past the row get an all-zero mask and are dropped
  assign w_mask   = {1'b1, {(WIDTH-1){1'b0}}} >> r_col;
  assign w_row_hs = r_state == EMIT && bus.row_ready;
`ifdef DAY7_ROW_CHECK_EN
  assign w_fault = !(w_lf || w_cr || w_hat || w_s || bus.in_data == CH_DOT) ||
                   (w_lf && r_col != '0 && r_col != CW'(WIDTH)) ||
                   (w_s && (r_row_index != 8'd0 || r_start_found));
  assign error   = r_state == ERR;
`else
  assign w_fault = 1'b0;
  assign error   = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? SCAN : IDLE;
      SCAN:    w_next = (w_acc && w_fault) ? ERR : (w_acc && w_lf && r_col != '0) ? EMIT : SCAN;
      EMIT:    w_next = !bus.row_ready ? EMIT : (r_row_index == 8'(HEIGHT - 1)) ? DONE : SCAN;
      default: w_next = r_state;
    endcase
  end
  // CR is a no-op; LF only rewinds the column (an empty line leaves everything as is)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col         <= '0;
      r_buf         <= '0;
      r_row_index   <= '0;
      r_start_col   <= '0;
      r_start_found <= 1'b0;
    end else if (w_row_hs) begin
      r_row_index <= r_row_index + 8'd1;
      r_buf       <= '0;
    end else if (w_acc && !w_fault && !w_cr) begin
      r_col <= w_lf ? '0 : (r_col == CW'(WIDTH + 1)) ? r_col : r_col + CW'(1);
      r_buf <= w_lf ? r_buf : w_hat ? (r_buf | w_mask) : (r_buf & ~w_mask);
      if (w_s && w_in_row && r_row_index == 8'd0 && !r_start_found) begin
        r_start_col   <= 8'(r_col);
        r_start_found <= 1'b1;
      end
    end
  end
  assign bus.in_ready  = r_state == SCAN;
  assign bus.row_valid = r_state == EMIT;
  assign bus.row_data  = r_buf;
  assign bus.row_index = r_row_index;
  assign start_col     = r_start_col;
  assign start_found   = r_start_found;
  assign finished      = r_state == DONE;
endmodule
